acumulador_pontos: RTL and testbench
====================================

ACUMULADOR_PONTOS -- requirements
Module: acumulador_pontos

Interface
REQ-001 Parameter W, default 8, width of score and record registers.
REQ-002 Parameter RW, default 4, width of round number.
REQ-003 Parameter EW, default 8, width of error count.
REQ-004 Parameter BASE, default 4, points per round step.
REQ-005 Parameter PEN, default 2, points deducted per error.
REQ-006 Parameter MULT_MAX, default 4, combo multiplier ceiling, legal range 1..7.
REQ-007 Ports, one per line:
- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- calcular  in  1  start request, sampled only in OCIOSO.
- zerar  in  1  synchronous clear of score and streak.
- rodada  in  RW  round number, 0-based.
- erros  in  EW  error count for the round.
- pontos  out  W  accumulated score.
- multiplicador  out  3  current combo multiplier (sequencia+1).
- ocupado  out  1  high while not in OCIOSO.
- pronto  out  1  one-cycle pulse when score is updated.
- saturou  out  1  one-cycle pulse with pronto when the result was clamped.
- recorde  out  W  best score since reset.
- novo_recorde  out  1  one-cycle pulse with pronto when recorde increased.

Function
REQ-008 FSM states: OCIOSO, BASE, MULT, APLICA, PRONTO; transitions OCIOSO->BASE on calcular, BASE->MULT->APLICA->PRONTO unconditionally, PRONTO->OCIOSO.
REQ-009 rodada and erros are captured on the edge leaving OCIOSO; later input changes do not affect that calculation.
REQ-010 BASE: ganho_base = (rodada+1)*BASE; perda = erros*PEN; sequencia_next = min(sequencia+1, MULT_MAX-1) if erros==0, else 0.
REQ-011 MULT: ganho = ganho_base*(sequencia_next+1).
REQ-012 APLICA: soma = pontos + ganho - perda in a signed intermediate of W+RW+EW+8 bits; clamp to [0, 2^W-1]; saturou_int = 1 if the clamp was applied.
REQ-013 PRONTO: pontos, sequencia, and (if enabled) recorde are updated; pronto=1 and saturou=saturou_int for exactly this cycle.
REQ-014 Latency: calcular high at edge N yields pronto high during cycle N+4; throughput is one calculation per 5 cycles.
REQ-015 calcular is ignored outside OCIOSO; no queuing.
REQ-016 zerar in any state clears pontos and sequencia and forces OCIOSO; an in-flight calculation aborts with no pronto pulse; recorde is kept.
REQ-017 zerar and calcular together in OCIOSO: zerar wins, no calculation starts.
REQ-018 ocupado = (state != OCIOSO), driven from a register.
REQ-019 multiplicador = sequencia+1, updated only in PRONTO or by zerar/reset.

Reset
REQ-020 reset_n low asynchronously sets state OCIOSO, pontos=0, sequencia=0 (multiplicador=1), recorde=0, and ocupado, pronto, saturou, novo_recorde=0.
REQ-021 Reset asserted mid-calculation discards that calculation; no pronto pulse after release.

Configuration
REQ-022 Macro ACUMULADOR_RECORDE_EN defined: in PRONTO, if the new pontos > recorde, then recorde <= new pontos and novo_recorde pulses.
REQ-023 Macro absent: no record register; recorde is tied to 0 and novo_recorde to 0; all other behaviour is unchanged.

Verification
REQ-024 After reset, four calculations with erros=0 and rodada=0,1,2,3 -> pontos 8, 32, 80, 144; multiplicador 2, 3, 4, 4.
REQ-025 From pontos=144 and multiplicador 4, rodada=15, erros=0 -> pontos=255, saturou=1, multiplicador stays 4.
REQ-026 From pontos=8, rodada=0, erros=10 -> pontos=0 (8+4-20 clamped), saturou=1, multiplicador=1.
REQ-027 calcular at edge N -> ocupado=1 from N+1, pronto only in cycle N+4, calcular pulses at N+1..N+3 ignored, one update only.
REQ-028 zerar during MULT -> pontos=0, multiplicador=1, no pronto; reset_n low during APLICA -> all outputs 0/1 per REQ-020 immediately.
REQ-029 With ACUMULADOR_RECORDE_EN: scores 80 then a drop to 0 -> recorde stays 80, novo_recorde pulses only on increases; without the macro -> recorde=0 always.

Source files
------------

// File: rtl/acumulador_pontos.sv
// Game score accumulator: five-state pipeline computing round gain, combo multiplier and error penalty.
// Optional best-score tracking is enabled by defining ACUMULADOR_RECORDE_EN.
module acumulador_pontos #(
  parameter int unsigned W        = 8,
  parameter int unsigned RW       = 4,
  parameter int unsigned EW       = 8,
  parameter int unsigned BASE     = 4,
  parameter int unsigned PEN      = 2,
  parameter int unsigned MULT_MAX = 4
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          calcular,
  input  logic          zerar,
  input  logic [RW-1:0] rodada,
  input  logic [EW-1:0] erros,
  output logic [W-1:0]  pontos,
  output logic [2:0]    multiplicador,
  output logic          ocupado,
  output logic          pronto,
  output logic          saturou,
  output logic [W-1:0]  recorde,
  output logic          novo_recorde
);

  localparam int unsigned SW = W + RW + EW + 8;
  localparam logic signed [SW-1:0] MAXV = {{(SW-W){1'b0}}, {W{1'b1}}};
  localparam logic [2:0] SEQ_MAX = 3'(MULT_MAX - 1);

  typedef enum logic [2:0] {S_OCIOSO, S_BASE, S_MULT, S_APLICA, S_PRONTO} estado_t;

  estado_t        estado_q, estado_d;
  logic [RW-1:0]  rodada_q, rodada_d;
  logic [EW-1:0]  erros_q, erros_d;
  logic [SW-1:0]  ganho_base_q, ganho_base_d;
  logic [SW-1:0]  perda_q, perda_d;
  logic [SW-1:0]  ganho_q, ganho_d;
  logic [2:0]     seq_next_q, seq_next_d;
  logic [2:0]     sequencia_q, sequencia_d;
  logic [2:0]     mult_q, mult_d;
  logic [W-1:0]   pontos_q, pontos_d;
  logic           ocupado_q, ocupado_d;
  logic           pronto_q, pronto_d;
  logic           saturou_q, saturou_d;
`ifdef ACUMULADOR_RECORDE_EN
  logic [W-1:0]   recorde_q, recorde_d;
  logic           novo_q, novo_d;
`endif

  logic signed [SW-1:0] soma_c;
  logic [W-1:0]         res_c;
  logic                 sat_c;

  // Signed sum and clamp to the unsigned score range
  always_comb begin
    soma_c = SW'(pontos_q) + ganho_q - perda_q;
    res_c  = W'(soma_c);
    sat_c  = 1'b0;
    if (soma_c[SW-1]) begin
      res_c = '0;
      sat_c = 1'b1;
    end else if (soma_c > MAXV) begin
      res_c = '1;
      sat_c = 1'b1;
    end
  end

  // Next-state and datapath; results land on the edge entering PRONTO so they show with pronto
  always_comb begin
    estado_d     = estado_q;
    rodada_d     = rodada_q;
    erros_d      = erros_q;
    ganho_base_d = ganho_base_q;
    perda_d      = perda_q;
    ganho_d      = ganho_q;
    seq_next_d   = seq_next_q;
    sequencia_d  = sequencia_q;
    mult_d       = mult_q;
    pontos_d     = pontos_q;
    pronto_d     = 1'b0;
    saturou_d    = 1'b0;
`ifdef ACUMULADOR_RECORDE_EN
    recorde_d    = recorde_q;
    novo_d       = 1'b0;
`endif
    case (estado_q)
      S_OCIOSO: begin
        if (calcular) begin
          estado_d = S_BASE;
          rodada_d = rodada;
          erros_d  = erros;
        end
      end
      S_BASE: begin
        ganho_base_d = (SW'(rodada_q) + SW'(1)) * SW'(BASE);
        perda_d      = SW'(erros_q) * SW'(PEN);
        if (erros_q != '0) seq_next_d = 3'd0;
        else if (sequencia_q >= SEQ_MAX) seq_next_d = SEQ_MAX;
        else seq_next_d = sequencia_q + 3'd1;
        estado_d = S_MULT;
      end
      S_MULT: begin
        ganho_d  = ganho_base_q * (SW'(seq_next_q) + SW'(1));
        estado_d = S_APLICA;
      end
      S_APLICA: begin
        pontos_d    = res_c;
        sequencia_d = seq_next_q;
        mult_d      = seq_next_q + 3'd1;
        pronto_d    = 1'b1;
        saturou_d   = sat_c;
`ifdef ACUMULADOR_RECORDE_EN
        if (res_c > recorde_q) begin
          recorde_d = res_c;
          novo_d    = 1'b1;
        end
`endif
        estado_d = S_PRONTO;
      end
      S_PRONTO: estado_d = S_OCIOSO;
      default:  estado_d = S_OCIOSO;
    endcase
    // Clear aborts anything in flight; the record survives
    if (zerar) begin
      estado_d    = S_OCIOSO;
      pontos_d    = '0;
      sequencia_d = 3'd0;
      mult_d      = 3'd1;
      pronto_d    = 1'b0;
      saturou_d   = 1'b0;
`ifdef ACUMULADOR_RECORDE_EN
      recorde_d   = recorde_q;
      novo_d      = 1'b0;
`endif
    end
    ocupado_d = (estado_d != S_OCIOSO);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      estado_q     <= S_OCIOSO;
      rodada_q     <= '0;
      erros_q      <= '0;
      ganho_base_q <= '0;
      perda_q      <= '0;
      ganho_q      <= '0;
      seq_next_q   <= 3'd0;
      sequencia_q  <= 3'd0;
      mult_q       <= 3'd1;
      pontos_q     <= '0;
      ocupado_q    <= 1'b0;
      pronto_q     <= 1'b0;
      saturou_q    <= 1'b0;
`ifdef ACUMULADOR_RECORDE_EN
      recorde_q    <= '0;
      novo_q       <= 1'b0;
`endif
    end else begin
      estado_q     <= estado_d;
      rodada_q     <= rodada_d;
      erros_q      <= erros_d;
      ganho_base_q <= ganho_base_d;
      perda_q      <= perda_d;
      ganho_q      <= ganho_d;
      seq_next_q   <= seq_next_d;
      sequencia_q  <= sequencia_d;
      mult_q       <= mult_d;
      pontos_q     <= pontos_d;
      ocupado_q    <= ocupado_d;
      pronto_q     <= pronto_d;
      saturou_q    <= saturou_d;
`ifdef ACUMULADOR_RECORDE_EN
      recorde_q    <= recorde_d;
      novo_q       <= novo_d;
`endif
    end
  end

  assign pontos        = pontos_q;
  assign multiplicador = mult_q;
  assign ocupado       = ocupado_q;
  assign pronto        = pronto_q;
  assign saturou       = saturou_q;
`ifdef ACUMULADOR_RECORDE_EN
  assign recorde       = recorde_q;
  assign novo_recorde  = novo_q;
`else
  assign recorde       = '0;
  assign novo_recorde  = 1'b0;
`endif

endmodule

// File: tb/tb_acumulador_pontos.sv
// Directed bench for acumulador_pontos; record expectations follow ACUMULADOR_RECORDE_EN.
module tb_acumulador_pontos;

  logic       clock;
  logic       reset_n;
  logic       calcular;
  logic       zerar;
  logic [3:0] rodada;
  logic [7:0] erros;
  logic [7:0] pontos;
  logic [2:0] multiplicador;
  logic       ocupado;
  logic       pronto;
  logic       saturou;
  logic [7:0] recorde;
  logic       novo_recorde;

  int checks = 0;
  int errors = 0;

  acumulador_pontos dut (
    .clock(clock), .reset_n(reset_n), .calcular(calcular), .zerar(zerar),
    .rodada(rodada), .erros(erros), .pontos(pontos), .multiplicador(multiplicador),
    .ocupado(ocupado), .pronto(pronto), .saturou(saturou), .recorde(recorde),
    .novo_recorde(novo_recorde)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // One full calculation: checks latency, pronto pulse width and results
  task automatic do_calc(input string tag, input logic [3:0] r, input logic [7:0] e,
                         input logic [7:0] ep, input logic [2:0] em, input logic es,
                         input logic [7:0] er, input logic en, input logic extra);
    logic [7:0] exp_r;
    logic       exp_n;
`ifdef ACUMULADOR_RECORDE_EN
    exp_r = er;
    exp_n = en;
`else
    exp_r = 8'd0;
    exp_n = 1'b0;
`endif
    calcular = 1'b1;
    rodada   = r;
    erros    = e;
    step();
    calcular = extra;
    rodada   = 4'hF;
    erros    = 8'd0;
    check({tag, "_ocupado"}, ocupado, 1);
    check({tag, "_pronto_n1"}, pronto, 0);
    step();
    check({tag, "_pronto_n2"}, pronto, 0);
    step();
    check({tag, "_pronto_n3"}, pronto, 0);
    step();
    calcular = 1'b0;
    check({tag, "_pronto"}, pronto, 1);
    check({tag, "_pontos"}, pontos, ep);
    check({tag, "_mult"}, multiplicador, em);
    check({tag, "_saturou"}, saturou, es);
    check({tag, "_recorde"}, recorde, exp_r);
    check({tag, "_novo"}, novo_recorde, exp_n);
    step();
    check({tag, "_pronto_off"}, pronto, 0);
    check({tag, "_ocupado_off"}, ocupado, 0);
    check({tag, "_sat_off"}, saturou, 0);
    check({tag, "_pontos_hold"}, pontos, ep);
  endtask

  initial begin
    reset_n  = 1'b0;
    calcular = 1'b0;
    zerar    = 1'b0;
    rodada   = 4'd0;
    erros    = 8'd0;
    step();
    step();
    check("rst_pontos", pontos, 0);
    check("rst_mult", multiplicador, 1);
    check("rst_ocupado", ocupado, 0);
    check("rst_pronto", pronto, 0);
    reset_n = 1'b1;
    step();
    check("idle_ocupado", ocupado, 0);
    check("idle_recorde", recorde, 0);

    // Record climbs to 80, then a penalty drop to 0 keeps it
    do_calc("c1", 4'd0, 8'd0,  8'd8,  3'd2, 1'b0, 8'd8,  1'b1, 1'b0);
    do_calc("c2", 4'd1, 8'd0,  8'd32, 3'd3, 1'b0, 8'd32, 1'b1, 1'b0);
    do_calc("c3", 4'd2, 8'd0,  8'd80, 3'd4, 1'b0, 8'd80, 1'b1, 1'b0);
    do_calc("c4", 4'd0, 8'd50, 8'd0,  3'd1, 1'b1, 8'd80, 1'b0, 1'b0);

    // zerar and calcular together in idle: no start
    zerar    = 1'b1;
    calcular = 1'b1;
    step();
    zerar    = 1'b0;
    calcular = 1'b0;
    check("zc_ocupado", ocupado, 0);
    check("zc_pontos", pontos, 0);
    check("zc_mult", multiplicador, 1);
    step();
    check("zc_ocupado2", ocupado, 0);
    check("zc_pronto", pronto, 0);

    // Four-round ramp then saturation high
    do_calc("r0",  4'd0,  8'd0, 8'd8,   3'd2, 1'b0, 8'd80,  1'b0, 1'b0);
    do_calc("r1",  4'd1,  8'd0, 8'd32,  3'd3, 1'b0, 8'd80,  1'b0, 1'b0);
    do_calc("r2",  4'd2,  8'd0, 8'd80,  3'd4, 1'b0, 8'd80,  1'b0, 1'b0);
    do_calc("r3",  4'd3,  8'd0, 8'd144, 3'd4, 1'b0, 8'd144, 1'b1, 1'b0);
    do_calc("r15", 4'd15, 8'd0, 8'd255, 3'd4, 1'b1, 8'd255, 1'b1, 1'b0);

    // Saturation low from 8
    zerar = 1'b1;
    step();
    zerar = 1'b0;
    do_calc("s0", 4'd0, 8'd0,  8'd8, 3'd2, 1'b0, 8'd255, 1'b0, 1'b0);
    do_calc("s1", 4'd0, 8'd10, 8'd0, 3'd1, 1'b1, 8'd255, 1'b0, 1'b0);

    // Extra calcular pulses during busy are ignored
    do_calc("ig", 4'd0, 8'd0, 8'd8, 3'd2, 1'b0, 8'd255, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      step();
      check("ig_no_pronto", pronto, 0);
      check("ig_pontos", pontos, 8);
    end

    // zerar during MULT aborts
    calcular = 1'b1;
    rodada   = 4'd1;
    erros    = 8'd0;
    step();
    calcular = 1'b0;
    step();
    zerar = 1'b1;
    step();
    zerar = 1'b0;
    check("zm_ocupado", ocupado, 0);
    check("zm_pronto", pronto, 0);
    check("zm_pontos", pontos, 0);
    check("zm_mult", multiplicador, 1);
    for (int i = 0; i < 4; i++) begin
      step();
      check("zm_no_pronto", pronto, 0);
      check("zm_pontos_hold", pontos, 0);
    end

    // Reset during APLICA
    calcular = 1'b1;
    rodada   = 4'd2;
    step();
    calcular = 1'b0;
    step();
    step();
    reset_n = 1'b0;
    #1;
    check("ra_pontos", pontos, 0);
    check("ra_mult", multiplicador, 1);
    check("ra_ocupado", ocupado, 0);
    check("ra_pronto", pronto, 0);
    check("ra_saturou", saturou, 0);
    check("ra_recorde", recorde, 0);
    check("ra_novo", novo_recorde, 0);
    step();
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("ra_no_pronto", pronto, 0);
      check("ra_pontos_hold", pontos, 0);
      check("ra_idle", ocupado, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
